adder_seq_ctrl: RTL and testbench

//  Operand sequencer for the 2-bit adder / 7-segment display datapath (A, B, CI in; segments a..g out).

---
 rtl/adder_seq_ctrl_pkg.sv | 15 +
 rtl/btn_sync_edge.sv | 32 +++
 rtl/adder_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared state encoding and width helper for the adder operand sequencer.
package adder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_PAUSE  = 2'd2
  } state_e;

  // Width of the {A,B,CI} index for operand width w
  function automatic int unsigned idx_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-FF synchronizer, rising-edge detect, registered one-cycle pulse.
// A level going high before edge k yields o_pulse high in the cycle after edge k+2.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_pulse;

  // Synchronize, keep previous level, register the rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_async;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pulse <= r_s2 & ~r_s3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Operand sequencer for the 2-bit adder: manual switch load, auto sweep of every {A,B,CI}
// with a fixed dwell per step, and pause/resume of the sweep.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_a,
  input  logic [W-1:0] sw_b,
  input  logic         sw_ci,
  input  logic         btn_load,
  input  logic         btn_mode,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic         CI,
  output logic         sweep_active,
  output logic [2*W:0] step_idx,
  output logic         update
);

  localparam int unsigned IDX_W = idx_width(W);
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  logic             w_load_p;
  logic             w_mode_p;
  logic [IDX_W-1:0] w_step_nxt;

  logic [IDX_W-1:0] r_sw_s1;
  logic [IDX_W-1:0] r_sw_s2;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_step;
  logic [IDX_W-1:0] r_abc;
  logic             r_update;
  logic             r_sweep_active;

  btn_sync_edge u_load_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(btn_load),
    .o_pulse(w_load_p)
  );

  btn_sync_edge u_mode_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(btn_mode),
    .o_pulse(w_mode_p)
  );

  // Switch bus synchronizer; loads use the same latency as the button path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= {sw_a, sw_b, sw_ci};
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign w_step_nxt = r_step + 1'b1;

  // Mode FSM with dwell counter, step counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_MANUAL;
      r_cnt          <= '0;
      r_step         <= '0;
      r_abc          <= '0;
      r_update       <= 1'b0;
      r_sweep_active <= 1'b0;
    end else begin
      r_update <= 1'b0;
      unique case (r_state)
        ST_MANUAL: begin
          if (w_mode_p) begin
            r_state        <= ST_SWEEP;
            r_sweep_active <= 1'b1;
            r_step         <= '0;
            r_cnt          <= '0;
            r_abc          <= '0;
            r_update       <= 1'b1;
          end else if (w_load_p) begin
            r_abc    <= r_sw_s2;
            r_update <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (w_mode_p) begin
            r_state        <= ST_MANUAL;
            r_sweep_active <= 1'b0;
          end else begin
            if (w_load_p) begin
              r_state        <= ST_PAUSE;
              r_sweep_active <= 1'b0;
            end
            // The pausing edge is still a sweep cycle, so each step keeps exactly DWELL
            // sweep cycles across a pause/resume.
            if (r_cnt == CNT_MAX) begin
              r_cnt    <= '0;
              r_step   <= w_step_nxt;
              r_abc    <= w_step_nxt;
              r_update <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (w_mode_p) begin
            r_state <= ST_MANUAL;
          end else if (w_load_p) begin
            r_state        <= ST_SWEEP;
            r_sweep_active <= 1'b1;
          end
        end
        default: begin
          r_state        <= ST_MANUAL;
          r_sweep_active <= 1'b0;
        end
      endcase
    end
  end

  assign A            = r_abc[2*W:W+1];
  assign B            = r_abc[W:1];
  assign CI           = r_abc[0];
  assign step_idx     = r_step;
  assign update       = r_update;
  assign sweep_active = r_sweep_active;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with W=2, DWELL=4.
module tb_adder_seq_ctrl;

  localparam int unsigned W     = 2;
  localparam int unsigned DWELL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_a;
  logic [W-1:0] sw_b;
  logic         sw_ci;
  logic         btn_load;
  logic         btn_mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         sweep_active;
  logic [2*W:0] step_idx;
  logic         update;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  adder_seq_ctrl #(
    .W    (W),
    .DWELL(DWELL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_a        (sw_a),
    .sw_b        (sw_b),
    .sw_ci       (sw_ci),
    .btn_load    (btn_load),
    .btn_mode    (btn_mode),
    .A           (A),
    .B           (B),
    .CI          (CI),
    .sweep_active(sweep_active),
    .step_idx    (step_idx),
    .update      (update)
  );

  always #5 clk = ~clk;

  // Count update pulses, sampled mid-cycle
  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  // Raise buttons before edge k, return just after edge k+3 (action edge) with buttons low.
  task automatic press(input logic l, input logic m);
    @(posedge clk); #1;
    btn_load = l;
    btn_mode = m;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    btn_load = 1'b0;
    btn_mode = 1'b0;
  endtask

  task automatic wait_idx(input logic [2*W:0] target, input string name);
    int n = 0;
    while (!(step_idx === target && update === 1'b1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s: timeout waiting for idx %0d, got idx %0d", name, target, step_idx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw_a = 2'd3; sw_b = 2'd3; sw_ci = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      btn_load = i[0];
      btn_mode = ~i[0];
    end
    n_tests++;
    if ({A, B, CI, step_idx, sweep_active} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got A=%0d B=%0d CI=%0d idx=%0d act=%0b, want all 0",
               A, B, CI, step_idx, sweep_active);
    end
    btn_load = 1'b0; btn_mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if ({A, B, CI, step_idx, sweep_active} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got A=%0d B=%0d CI=%0d idx=%0d, want all 0",
               A, B, CI, step_idx);
    end
    n_tests++;
    if (upd_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_update: got %0d update pulses, want 0", upd_cnt);
    end
  endtask

  task automatic test_manual_load;
    sw_a = 2'd2; sw_b = 2'd1; sw_ci = 1'b1;
    repeat (3) @(posedge clk);
    upd_cnt = 0;
    @(posedge clk); #1;
    btn_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({A, B, CI} !== 5'd0 || update !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_early: got A=%0d B=%0d CI=%0d upd=%0b at edge k+2, want 0",
               A, B, CI, update);
    end
    @(posedge clk); #1;
    btn_load = 1'b0;
    n_tests++;
    if (A !== 2'd2 || B !== 2'd1 || CI !== 1'b1 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_load: got A=%0d B=%0d CI=%0d upd=%0b, want A=2 B=1 CI=1 upd=1",
               A, B, CI, update);
    end
    n_tests++;
    if (step_idx !== 5'd0 || sweep_active !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_idx: got idx=%0d act=%0b, want 0 0", step_idx, sweep_active);
    end
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (upd_cnt != 1) begin
      n_fail++;
      $display("FAIL manual_pulses: got %0d update pulses, want 1", upd_cnt);
    end
  endtask

  task automatic test_sweep;
    int errs = 0;
    logic [2*W:0] exp_idx;
    press(1'b0, 1'b1);
    n_tests++;
    if (sweep_active !== 1'b1 || step_idx !== 5'd0 || {A, B, CI} !== 5'd0 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_enter: got act=%0b idx=%0d abc=%0d upd=%0b, want 1 0 0 1",
               sweep_active, step_idx, {A, B, CI}, update);
    end
    // 34 steps of DWELL cycles each, covering the 31 -> 0 wrap
    for (int s = 0; s < 34; s++) begin
      exp_idx = 5'(s);
      for (int c = 0; c < int'(DWELL); c++) begin
        if (step_idx !== exp_idx || {A, B, CI} !== exp_idx || update !== (c == 0)) begin
          errs++;
          if (errs < 4)
            $display("FAIL sweep_step: step %0d cyc %0d got idx=%0d abc=%0d upd=%0b, want %0d",
                     s, c, step_idx, {A, B, CI}, update, exp_idx);
        end
        @(posedge clk); #1;
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    n_tests++;
    if (step_idx !== 5'd2) begin
      n_fail++;
      $display("FAIL sweep_wrap: got idx=%0d after 34 steps, want 2", step_idx);
    end
  endtask

  task automatic test_pause;
    int errs = 0;
    wait_idx(5'd4, "pause_wait4");
    // Action edge lands one edge after idx 5 begins
    press(1'b1, 1'b0);
    n_tests++;
    if (sweep_active !== 1'b0 || step_idx !== 5'd5) begin
      n_fail++;
      $display("FAIL pause_enter: got act=%0b idx=%0d, want 0 5", sweep_active, step_idx);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (step_idx !== 5'd5 || update !== 1'b0 || sweep_active !== 1'b0) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL pause_hold: %0d frozen-cycle errors, idx now %0d, want 5", errs, step_idx);
    end
    press(1'b1, 1'b0);
    n_tests++;
    if (sweep_active !== 1'b1 || step_idx !== 5'd5 || update !== 1'b0) begin
      n_fail++;
      $display("FAIL resume: got act=%0b idx=%0d upd=%0b, want 1 5 0",
               sweep_active, step_idx, update);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (step_idx !== 5'd5) begin
      n_fail++;
      $display("FAIL resume_rest: got idx=%0d two cycles after resume, want 5", step_idx);
    end
    @(posedge clk); #1;
    n_tests++;
    if (step_idx !== 5'd6 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_next: got idx=%0d upd=%0b, want 6 1", step_idx, update);
    end
  endtask

  task automatic test_both_pulses;
    int errs = 0;
    // Now just after the edge that started idx 6; action edge lands after idx 7 begins
    press(1'b1, 1'b1);
    n_tests++;
    if (sweep_active !== 1'b0 || step_idx !== 5'd7 || A !== 2'd0 || B !== 2'd3 || CI !== 1'b1) begin
      n_fail++;
      $display("FAIL both_leave: got act=%0b idx=%0d A=%0d B=%0d CI=%0d, want 0 7 0 3 1",
               sweep_active, step_idx, A, B, CI);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({A, B, CI} !== 5'd7 || update !== 1'b0 || step_idx !== 5'd7) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL both_hold: %0d hold errors, abc now %0d, want 7", errs, {A, B, CI});
    end
    // From MANUAL, mode re-enters SWEEP at idx 0 (from PAUSE it would stay out of SWEEP)
    press(1'b0, 1'b1);
    n_tests++;
    if (sweep_active !== 1'b1 || step_idx !== 5'd0 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL both_was_manual: got act=%0b idx=%0d upd=%0b, want 1 0 1",
               sweep_active, step_idx, update);
    end
  endtask

  task automatic test_reset_mid;
    wait_idx(5'd9, "rst_wait9");
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({A, B, CI, step_idx, sweep_active, update} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got A=%0d B=%0d CI=%0d idx=%0d act=%0b, want all 0",
               A, B, CI, step_idx, sweep_active);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (sweep_active !== 1'b0 || step_idx !== 5'd0 || {A, B, CI} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got act=%0b idx=%0d abc=%0d, want 0 0 0",
               sweep_active, step_idx, {A, B, CI});
    end
    sw_a = 2'd1; sw_b = 2'd3; sw_ci = 1'b0;
    repeat (3) @(posedge clk);
    press(1'b1, 1'b0);
    n_tests++;
    if (A !== 2'd1 || B !== 2'd3 || CI !== 1'b0 || sweep_active !== 1'b0 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_manual: got A=%0d B=%0d CI=%0d act=%0b upd=%0b, want 1 3 0 0 1",
               A, B, CI, sweep_active, update);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw_a = '0; sw_b = '0; sw_ci = 1'b0;
    btn_load = 1'b0; btn_mode = 1'b0;
    test_reset();
    test_manual_load();
    test_sweep();
    test_pause();
    test_both_pulses();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
